// File: rtl/instruction_fetch.sv
// Instruction fetch unit: PC with wrap/redirect feeding a 2-entry prefetch buffer.
// Optional halt-on-opcode behaviour is enabled by defining FETCH_HALT_EN.
module instruction_fetch #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int MEM_DEPTH = 6,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDRESS = '0,
  parameter logic [DATA_WIDTH-1:0] HALT_OPCODE = 8'hFF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  output logic [ADDR_WIDTH-1:0] instruction_address,
  input  logic [DATA_WIDTH-1:0] instruction_data,
  input  logic                  fetch_enable,
  input  logic                  branch_valid,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  output logic                  decode_valid,
  output logic [DATA_WIDTH-1:0] decode_instruction,
  output logic [ADDR_WIDTH-1:0] decode_address,
  input  logic                  decode_ready,
  output logic                  halted
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDRESS = ADDR_WIDTH'(MEM_DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH = (ADDR_WIDTH + 1)'(MEM_DEPTH);

  logic [1:0]            count;
  logic [ADDR_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] tail_instruction;
  logic [ADDR_WIDTH-1:0] tail_address;
  logic                  pop;
  logic                  push;
  logic                  halt_hit;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic [ADDR_WIDTH-1:0] sequential_pc;

`ifdef FETCH_HALT_EN
  logic halt_state;
  assign halted   = halt_state;
  assign halt_hit = (instruction_data == HALT_OPCODE);
`else
  assign halted   = 1'b0;
  // Constant zero: the halt opcode is an ordinary instruction in this build.
  assign halt_hit = 1'b0 & (instruction_data == HALT_OPCODE);
`endif

  assign instruction_address = pc;
  assign decode_valid  = (count != 2'd0);
  assign pop           = decode_valid && decode_ready;
  assign push          = fetch_enable && !halted && !branch_valid && ((count != 2'd2) || pop);
  assign redirect_pc   = ({1'b0, branch_target} < DEPTH) ? branch_target : RESET_ADDRESS;
  assign sequential_pc = (pc == LAST_ADDRESS) ? '0 : pc + 1'b1;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc                 <= RESET_ADDRESS;
      count              <= 2'd0;
      decode_instruction <= '0;
      decode_address     <= '0;
      tail_instruction   <= '0;
      tail_address       <= '0;
`ifdef FETCH_HALT_EN
      halt_state         <= 1'b0;
`endif
    end else if (branch_valid) begin
      pc    <= redirect_pc;
      count <= 2'd0;
`ifdef FETCH_HALT_EN
      halt_state <= 1'b0;
`endif
    end else begin
      if (push) begin
        // A halt word is stored, but the PC stays parked on its address.
        pc <= halt_hit ? pc : sequential_pc;
`ifdef FETCH_HALT_EN
        halt_state <= halt_hit;
`endif
      end
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            decode_instruction <= instruction_data;
            decode_address     <= pc;
          end else begin
            tail_instruction <= instruction_data;
            tail_address     <= pc;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          if (count == 2'd2) begin
            decode_instruction <= tail_instruction;
            decode_address     <= tail_address;
          end
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            decode_instruction <= instruction_data;
            decode_address     <= pc;
          end else begin
            decode_instruction <= tail_instruction;
            decode_address     <= tail_address;
            tail_instruction   <= instruction_data;
            tail_address       <= pc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
